// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the IF (read-only) and MEM
// (load/store) pipeline stages, serialising accesses and hiding read latency.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_ack_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              stall_if_o,
    output logic              stall_mem_o,
    output logic              busy_o
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                w_grant;
    logic                w_grant_dm;
    logic                w_capture;
    logic                r_owner_dm;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [CNT_W-1:0]    r_lat_cnt;
    logic [CNT_W-1:0]    r_starve_cnt;
    logic [DATA_W-1:0]   r_if_data;
    logic [DATA_W-1:0]   r_dm_rdata;
    logic                r_mem_en;
    logic                r_mem_we;
    logic                r_if_ack;
    logic                r_dm_ack;
    logic                r_busy;

    // Next-state and arbitration; DM has priority unless IF has been starved.
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_grant_dm   = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (if_req_i || dm_req_i) begin
                    w_grant      = 1'b1;
                    w_grant_dm   = dm_req_i &&
                                   !(if_req_i && (r_starve_cnt == CNT_W'(STARVE_MAX)));
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: w_next_state = r_we ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (r_lat_cnt == CNT_W'(1)) begin
                    w_capture    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_owner_dm   <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_lat_cnt    <= '0;
            r_starve_cnt <= '0;
            r_if_data    <= '0;
            r_dm_rdata   <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_mem_en <= (w_next_state == S_ACCESS);
            r_mem_we <= (w_next_state == S_ACCESS) && w_grant_dm && dm_we_i;
            r_if_ack <= (w_next_state == S_RESP) && !r_owner_dm;
            r_dm_ack <= (w_next_state == S_RESP) && r_owner_dm;
            r_busy   <= (w_next_state != S_IDLE);

            if (w_grant) begin
                r_owner_dm <= w_grant_dm;
                r_we       <= w_grant_dm && dm_we_i;
                r_addr     <= w_grant_dm ? dm_addr_i : if_addr_i;
                r_wdata    <= w_grant_dm ? dm_wdata_i : '0;
                if (!w_grant_dm) begin
                    r_starve_cnt <= '0;
                end else if (if_req_i && (r_starve_cnt != CNT_W'(STARVE_MAX))) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end

            if (r_state == S_ACCESS) begin
                r_lat_cnt <= CNT_W'(MEM_LAT);
            end else if (r_state == S_WAIT) begin
                r_lat_cnt <= r_lat_cnt - CNT_W'(1);
            end

            // Each owner's data register holds until its next read completes.
            if (w_capture) begin
                if (r_owner_dm) begin
                    r_dm_rdata <= mem_rdata_i;
                end else begin
                    r_if_data <= mem_rdata_i;
                end
            end
        end
    end

    assign if_ack_o    = r_if_ack;
    assign if_data_o   = r_if_data;
    assign dm_ack_o    = r_dm_ack;
    assign dm_rdata_o  = r_dm_rdata;
    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign busy_o      = r_busy;
    assign stall_if_o  = if_req_i & ~r_if_ack;
    assign stall_mem_o = dm_req_i & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: MEM_LAT=2 instance plus a MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
    logic        if_ack_o, dm_ack_o, mem_en_o, mem_we_o, stall_if_o, stall_mem_o, busy_o;
    logic [31:0] if_data_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

    logic        b_if_req, b_dm_req, b_dm_we;
    logic [31:0] b_if_addr, b_dm_addr, b_dm_wdata, b_mem_rdata;
    logic        b_if_ack, b_dm_ack, b_mem_en, b_mem_we, b_stall_if, b_stall_mem, b_busy;
    logic [31:0] b_if_data, b_dm_rdata, b_mem_addr, b_mem_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_data_o(if_data_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
        .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o), .busy_o(busy_o)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) dut_lat1 (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_ack_o(b_if_ack), .if_data_o(b_if_data),
        .dm_req_i(b_dm_req), .dm_we_i(b_dm_we), .dm_addr_i(b_dm_addr), .dm_wdata_i(b_dm_wdata),
        .dm_ack_o(b_dm_ack), .dm_rdata_o(b_dm_rdata),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
        .stall_if_o(b_stall_if), .stall_mem_o(b_stall_mem), .busy_o(b_busy)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        if_req_i = 0; if_addr_i = '0; dm_req_i = 0; dm_we_i = 0;
        dm_addr_i = '0; dm_wdata_i = '0; mem_rdata_i = '0;
        b_if_req = 0; b_if_addr = '0; b_dm_req = 0; b_dm_we = 0;
        b_dm_addr = '0; b_dm_wdata = '0; b_mem_rdata = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 3;
        if ({if_ack_o, dm_ack_o, mem_en_o, mem_we_o, busy_o, stall_if_o, stall_mem_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000000",
                     {if_ack_o, dm_ack_o, mem_en_o, mem_we_o, busy_o, stall_if_o, stall_mem_o});
        end
        if ({if_data_o, dm_rdata_o} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%h expected 0/0", if_data_o, dm_rdata_o);
        end
        if ({b_if_ack, b_dm_ack, b_mem_en, b_busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_lat1: got %b expected 0000", {b_if_ack, b_dm_ack, b_mem_en, b_busy});
        end
    endtask

    task automatic test_if_read();
        apply_reset();
        for (int c = 0; c <= 5; c++) begin
            step();
            if (c == 0) begin if_req_i = 1; if_addr_i = 32'h40; end
            if (c == 5) if_req_i = 0;
            mem_rdata_i = (c == 3) ? 32'hDEADBEEF : 32'h0;
            @(negedge clk_i);
            n_checks += 4;
            if (mem_en_o !== (c == 1)) begin
                n_fail++; $display("FAIL ifrd_mem_en c%0d: got %b expected %b", c, mem_en_o, c == 1);
            end
            if (if_ack_o !== (c == 4)) begin
                n_fail++; $display("FAIL ifrd_ack c%0d: got %b expected %b", c, if_ack_o, c == 4);
            end
            if (stall_if_o !== (c <= 3)) begin
                n_fail++; $display("FAIL ifrd_stall c%0d: got %b expected %b", c, stall_if_o, c <= 3);
            end
            if (busy_o !== (c >= 1 && c <= 4)) begin
                n_fail++; $display("FAIL ifrd_busy c%0d: got %b expected %b", c, busy_o, c >= 1 && c <= 4);
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr_o !== 32'h40 || mem_we_o !== 1'b0) begin
                    n_fail++; $display("FAIL ifrd_addr: got %h we %b expected 00000040 we 0", mem_addr_o, mem_we_o);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (if_data_o !== 32'hDEADBEEF) begin
                    n_fail++; $display("FAIL ifrd_data: got %h expected deadbeef", if_data_o);
                end
            end
        end
    endtask

    task automatic test_dm_store();
        apply_reset();
        for (int c = 0; c <= 4; c++) begin
            step();
            if (c == 0) begin
                dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h100; dm_wdata_i = 32'h12345678;
            end
            if (c == 3) dm_req_i = 0;
            @(negedge clk_i);
            n_checks += 4;
            if (mem_en_o !== (c == 1) || mem_we_o !== (c == 1)) begin
                n_fail++; $display("FAIL st_en_we c%0d: got %b%b expected %b%b", c, mem_en_o, mem_we_o, c == 1, c == 1);
            end
            if (dm_ack_o !== (c == 2)) begin
                n_fail++; $display("FAIL st_ack c%0d: got %b expected %b", c, dm_ack_o, c == 2);
            end
            if (busy_o !== (c == 1 || c == 2)) begin
                n_fail++; $display("FAIL st_busy c%0d: got %b expected %b", c, busy_o, c == 1 || c == 2);
            end
            if (stall_mem_o !== (c <= 1)) begin
                n_fail++; $display("FAIL st_stall c%0d: got %b expected %b", c, stall_mem_o, c <= 1);
            end
            if (c == 1) begin
                n_checks++;
                if (mem_addr_o !== 32'h100 || mem_wdata_o !== 32'h12345678) begin
                    n_fail++; $display("FAIL st_payload: got %h/%h expected 00000100/12345678", mem_addr_o, mem_wdata_o);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (dm_rdata_o !== 32'h0) begin
                    n_fail++; $display("FAIL st_rdata_hold: got %h expected 00000000", dm_rdata_o);
                end
            end
        end
    endtask

    task automatic test_contention();
        apply_reset();
        for (int c = 0; c <= 10; c++) begin
            step();
            if (c == 0) begin
                if_req_i = 1; if_addr_i = 32'h0;
                dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h8;
            end
            if (c == 5)  dm_req_i = 0;
            if (c == 10) if_req_i = 0;
            mem_rdata_i = (c == 3) ? 32'hAAAA0008 : ((c == 8) ? 32'hBBBB0000 : 32'h0);
            @(negedge clk_i);
            n_checks += 4;
            if (mem_en_o !== (c == 1 || c == 6)) begin
                n_fail++; $display("FAIL cont_mem_en c%0d: got %b expected %b", c, mem_en_o, c == 1 || c == 6);
            end
            if (dm_ack_o !== (c == 4)) begin
                n_fail++; $display("FAIL cont_dm_ack c%0d: got %b expected %b", c, dm_ack_o, c == 4);
            end
            if (if_ack_o !== (c == 9)) begin
                n_fail++; $display("FAIL cont_if_ack c%0d: got %b expected %b", c, if_ack_o, c == 9);
            end
            if (stall_if_o !== (c <= 8)) begin
                n_fail++; $display("FAIL cont_stall_if c%0d: got %b expected %b", c, stall_if_o, c <= 8);
            end
            if (c == 1 || c == 6) begin
                n_checks++;
                if (mem_addr_o !== ((c == 1) ? 32'h8 : 32'h0)) begin
                    n_fail++; $display("FAIL cont_addr c%0d: got %h expected %h", c, mem_addr_o, (c == 1) ? 32'h8 : 32'h0);
                end
            end
            if (c == 4 || c == 9) begin
                n_checks++;
                if ((c == 4 && dm_rdata_o !== 32'hAAAA0008) || (c == 9 && if_data_o !== 32'hBBBB0000)) begin
                    n_fail++; $display("FAIL cont_data c%0d: got dm %h if %h expected aaaa0008/bbbb0000", c, dm_rdata_o, if_data_o);
                end
            end
        end
    endtask

    task automatic test_starvation();
        int          got;
        logic [31:0] seen [10];
        logic [31:0] exp_addr;
        apply_reset();
        got = 0;
        for (int i = 0; i < 10; i++) seen[i] = '0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (c == 0) begin
                if_req_i = 1; if_addr_i = 32'h200;
                dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h300; dm_wdata_i = 32'h5A5A5A5A;
                mem_rdata_i = 32'h11111111;
            end
            @(negedge clk_i);
            if (mem_en_o === 1'b1 && got < 10) begin
                seen[got] = mem_addr_o;
                got++;
            end
        end
        idle_inputs();
        n_checks++;
        if (got < 10) begin
            n_fail++; $display("FAIL starve_timeout: got %0d grants expected 10", got);
        end
        for (int i = 0; i < 10; i++) begin
            exp_addr = (i == 4 || i == 9) ? 32'h200 : 32'h300;
            n_checks++;
            if (seen[i] !== exp_addr) begin
                n_fail++; $display("FAIL starve_grant%0d: got %h expected %h", i, seen[i], exp_addr);
            end
        end
    endtask

    task automatic test_reset_mid_access();
        apply_reset();
        for (int c = 0; c <= 7; c++) begin
            step();
            if (c == 0) begin dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h44; end
            if (c == 7) dm_req_i = 0;
            mem_rdata_i = (c == 3) ? 32'hCAFE0001 : ((c == 5) ? 32'h5555AAAA : 32'h0);
            if (c == 2) begin
                rst_i = 1'b1;
                #1;
                n_checks++;
                if ({busy_o, mem_en_o, if_ack_o, dm_ack_o} !== 4'b0) begin
                    n_fail++; $display("FAIL rst_async: got %b expected 0000", {busy_o, mem_en_o, if_ack_o, dm_ack_o});
                end
            end
            @(negedge clk_i);
            if (c == 2) rst_i = 1'b0;
            if (c >= 2) begin
                n_checks += 2;
                if (dm_ack_o !== (c == 6)) begin
                    n_fail++; $display("FAIL rst_dm_ack c%0d: got %b expected %b", c, dm_ack_o, c == 6);
                end
                if (mem_en_o !== (c == 3)) begin
                    n_fail++; $display("FAIL rst_mem_en c%0d: got %b expected %b", c, mem_en_o, c == 3);
                end
            end
            if (c == 6) begin
                n_checks++;
                if (dm_rdata_o !== 32'h5555AAAA) begin
                    n_fail++; $display("FAIL rst_reissue_data: got %h expected 5555aaaa", dm_rdata_o);
                end
            end
        end
    endtask

    task automatic test_addr_change();
        apply_reset();
        for (int c = 0; c <= 4; c++) begin
            step();
            if (c == 0) begin b_dm_req = 1; b_dm_we = 0; b_dm_addr = 32'h80; end
            if (c == 1) b_dm_addr = 32'h99;
            if (c == 4) b_dm_req = 0;
            b_mem_rdata = (c == 2) ? 32'h0BADF00D : 32'h0;
            @(negedge clk_i);
            n_checks += 2;
            if (b_mem_en !== (c == 1)) begin
                n_fail++; $display("FAIL lat1_mem_en c%0d: got %b expected %b", c, b_mem_en, c == 1);
            end
            if (b_dm_ack !== (c == 3)) begin
                n_fail++; $display("FAIL lat1_ack c%0d: got %b expected %b", c, b_dm_ack, c == 3);
            end
            if (c == 1) begin
                n_checks++;
                if (b_mem_addr !== 32'h80) begin
                    n_fail++; $display("FAIL lat1_addr_latched: got %h expected 00000080", b_mem_addr);
                end
            end
            if (c == 3) begin
                n_checks++;
                if (b_dm_rdata !== 32'h0BADF00D) begin
                    n_fail++; $display("FAIL lat1_data: got %h expected 0badf00d", b_dm_rdata);
                end
            end
        end
    endtask

    initial begin
        rst_i = 1'b1;
        idle_inputs();
        test_reset();
        test_if_read();
        test_dm_store();
        test_contention();
        test_starvation();
        test_reset_mid_access();
        test_addr_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
